wishbone_arbiter2: RTL and testbench
====================================

Name: wishbone_arbiter2

Overview:
Two-master, round-robin arbiter sharing one pipelined Wishbone bus toward the peripheral slaves (LED/register slaves on 2-bit word addresses).
- The winning master gets the bus for its whole cycle, until it drops CYC.
- The losing master sees stall and never receives ack or err.
- Sits between CPU/debug masters and the slave decoder.

Parameters:
AW, 2, address width
DW, 32, data width
OUTW, 4, outstanding-request counter width
TIMEOUT, 255, watchdog limit in cycles (used only with WB_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_mN_cyc, i_mN_stb, i_mN_we  in  1 each  master N request (N=0,1)
i_mN_addr  in  AW  master N address
i_mN_data  in  DW  master N write data
o_mN_ack, o_mN_stall, o_mN_err  out  1 each  master N response
o_mN_data  out  DW  master N read data
o_s_cyc, o_s_stb, o_s_we  out  1 each  shared bus request
o_s_addr  out  AW  shared bus address
o_s_data  out  DW  shared bus write data
i_s_ack, i_s_stall, i_s_err  in  1 each  slave response
i_s_data  in  DW  slave read data
o_grant  out  2  one-hot current owner; 00 when idle

Behaviour:
Reset values:
- Bus state IDLE, o_grant=00, last_owner=1 (so master 0 wins the first tie), outstanding=0.
- o_s_cyc=0, o_s_stb=0, o_mN_ack=0, o_mN_err=0, o_mN_stall=1.

States: IDLE, OWN0, OWN1.

IDLE:
- No grant; both masters see stall=1.
- Single requester: next edge moves to OWNk for that requester.
- Both requesting: grant the master that is not last_owner.
- Arbitration latency is 1 cycle from CYC rise to grant.

OWNk:
- o_s_cyc = i_mk_cyc, o_s_stb = i_mk_stb; we/addr/data muxed combinationally from master k.
- o_mk_stall = i_s_stall; o_mk_ack/err = i_s_ack/err; o_mk_data = i_s_data.
- Other master: stall=1, ack=0, err=0, data=0.

Leaving OWNk:
- When i_mk_cyc=0 at an edge: go to IDLE, set last_owner=k, clear outstanding.
- There is at least one IDLE cycle between owners; no same-cycle handoff.
- A request from the other master held during OWNk is granted on the IDLE cycle's edge.

Outstanding counter:
- +1 on accepted strobe (stb & !stall); -1 on ack|err; net 0 when both occur in one cycle.
- Saturates at 2^OUTW-1; while saturated, the owner sees stall=1 and o_s_stb is forced to 0.

Slave responses:
- err passes through unchanged, like ack.
- ack or err with outstanding=0 is dropped and not forwarded.

Other rules:
- Master dropping CYC mid-transaction abandons pending acks; they are dropped in IDLE.
- i_reset during OWNk: next edge returns to reset values regardless of bus activity.

Optional Feature:
WB_TIMEOUT_EN.

Defined:
- Watchdog counter clears on any ack/err or on state change.
- It increments each cycle in OWNk while outstanding>0.
- On reaching TIMEOUT: pulse o_mk_err for 1 cycle, force o_s_cyc=0 that cycle, go to IDLE with last_owner=k.

Undefined:
- No watchdog; a hung slave holds the bus indefinitely.

Decomposition:
- Package wb_arb_pkg holds the state enum (IDLE/OWN0/OWN1) and the default AW, DW and OUTW constants.
- Sub-module wb_rr_pick: combinational 2-way round-robin picker with inputs req[1:0] and last_owner, output one-hot pick. Reused for wider arbiters later.

Test Plan:
1. Reset release, m0 cyc+stb we=1 addr=1 data=1 -> o_grant=01 one cycle later; o_s_addr=1, o_s_data=1; ack reaches m0 only; m1 stall=1.
2. m0 and m1 raise cyc in the same cycle, three times back-to-back -> grants go m0, m1, m0, with exactly one IDLE cycle between owners.
3. m0 issues 3 pipelined reads, slave stalls 2 cycles then acks with data 0xA5A5_0001..3 -> m0 receives 3 acks in order; outstanding returns to 0.
4. Slave asserts err for m1's write -> o_m1_err=1 for 1 cycle, o_m0_err stays 0; grant holds until m1 drops cyc.
5. i_reset asserted in OWN1 with 2 outstanding -> next edge o_grant=00, o_s_cyc=0; late slave ack is not forwarded.
6. (WB_TIMEOUT_EN, TIMEOUT=8) m0 strobes and slave never acks -> o_m0_err pulses exactly 8 cycles after acceptance; bus returns to IDLE and m1 is granted next.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus ownership
// states and the default bus geometry used by the arbiter and its picker.
package wb_arb_pkg;

  // Bus ownership: nobody, master 0, or master 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } bus_state_e;

  // Default geometry for the peripheral bus (2-bit word addresses).
  localparam int AW_DEF   = 2;
  localparam int DW_DEF   = 32;
  localparam int OUTW_DEF = 4;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; on a tie the master that did not own the
// bus last time wins. The output is one-hot, or zero when nobody requests.
module wb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick
);

  // Resolve the request pair into a single one-hot winner.
  always_comb begin
    pick = 2'b00;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_owner ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/wishbone_arbiter2.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone bus.
// The winner keeps the bus for its whole CYC; the loser sees stall and
// never receives ack/err. At least one IDLE cycle separates two owners.
// Optional build macro WB_TIMEOUT_EN adds a watchdog that errors out a
// transaction whose slave stays silent for TIMEOUT cycles.
module wishbone_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int OUTW    = OUTW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  // master 0
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_data,
  output logic          o_m0_ack,
  output logic          o_m0_stall,
  output logic          o_m0_err,
  output logic [DW-1:0] o_m0_data,
  // master 1
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_data,
  output logic          o_m1_ack,
  output logic          o_m1_stall,
  output logic          o_m1_err,
  output logic [DW-1:0] o_m1_data,
  // shared slave side
  output logic          o_s_cyc,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  input  logic          i_s_ack,
  input  logic          i_s_stall,
  input  logic          i_s_err,
  input  logic [DW-1:0] i_s_data,
  output logic [1:0]    o_grant
);

  bus_state_e      state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic [OUTW-1:0] outst_q, outst_d;

  logic [1:0]      req;
  logic [1:0]      pick;
  logic            own_any;
  logic            own1;
  logic            sel_cyc;
  logic            sel_stb;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sat;
  logic            live;
  logic            accept;
  logic            respond;
  logic            timeout_hit;

  assign req = {i_m1_cyc, i_m0_cyc};

  wb_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick)
  );

  // The owner's request lines, selected once and reused everywhere below.
  assign own_any  = (state_q != IDLE);
  assign own1     = (state_q == OWN1);
  assign sel_cyc  = own1 ? i_m1_cyc  : i_m0_cyc;
  assign sel_stb  = own1 ? i_m1_stb  : i_m0_stb;
  assign sel_we   = own1 ? i_m1_we   : i_m0_we;
  assign sel_addr = own1 ? i_m1_addr : i_m0_addr;
  assign sel_data = own1 ? i_m1_data : i_m0_data;

  // A full counter throttles the owner; responses only count when a request
  // is actually in flight, so stray or abandoned acks are swallowed.
  assign sat     = &outst_q;
  assign live    = |outst_q;
  assign accept  = own_any & sel_stb & ~sat & ~timeout_hit & ~i_s_stall;
  assign respond = own_any & (i_s_ack | i_s_err) & live;

  // Next ownership state, outstanding count and all bus/master outputs.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    outst_d      = outst_q;
    o_grant      = 2'b00;
    o_s_cyc      = 1'b0;
    o_s_stb      = 1'b0;
    o_s_we       = 1'b0;
    o_s_addr     = '0;
    o_s_data     = '0;
    o_m0_ack     = 1'b0;
    o_m0_err     = 1'b0;
    o_m0_stall   = 1'b1;
    o_m0_data    = '0;
    o_m1_ack     = 1'b0;
    o_m1_err     = 1'b0;
    o_m1_stall   = 1'b1;
    o_m1_data    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick[0]) begin
          state_d = OWN0;
        end else if (pick[1]) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        o_grant  = own1 ? 2'b10 : 2'b01;
        o_s_cyc  = sel_cyc & ~timeout_hit;
        o_s_stb  = sel_stb & ~sat & ~timeout_hit;
        o_s_we   = sel_we;
        o_s_addr = sel_addr;
        o_s_data = sel_data;

        if (own1) begin
          o_m1_stall = i_s_stall | sat;
          o_m1_ack   = i_s_ack & live;
          o_m1_err   = (i_s_err & live) | timeout_hit;
          o_m1_data  = i_s_data;
        end else begin
          o_m0_stall = i_s_stall | sat;
          o_m0_ack   = i_s_ack & live;
          o_m0_err   = (i_s_err & live) | timeout_hit;
          o_m0_data  = i_s_data;
        end

        // Owner releases the bus (or the watchdog takes it away): pending
        // responses are abandoned and the other master wins the next tie.
        if (!sel_cyc || timeout_hit) begin
          state_d      = IDLE;
          last_owner_d = own1;
          outst_d      = '0;
        end else if (accept && !respond) begin
          outst_d = outst_q + OUTW'(1);
        end else if (!accept && respond) begin
          outst_d = outst_q - OUTW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ownership, round-robin pointer and outstanding-request registers.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (i_reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      outst_q      <= outst_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1; the expiring cycle is the TIMEOUT-th.
  localparam int              WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wdog_q, wdog_d;

  // Expire on the cycle the silent count would reach TIMEOUT, unless the
  // slave finally answers in that very cycle.
  assign timeout_hit = own_any & live & ~(i_s_ack | i_s_err) & (wdog_q == WDOG_LAST);

  // Count owned cycles with work in flight; any response or ownership change restarts it.
  always_comb begin
    wdog_d = wdog_q;
    if (!own_any || i_s_ack || i_s_err || (state_d != state_q)) begin
      wdog_d = '0;
    end else if (live) begin
      wdog_d = wdog_q + WDW'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // No watchdog: a hung slave holds the bus. TIMEOUT stays in the parameter
  // list so both builds share one interface; here it folds to a constant 0.
  assign timeout_hit = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Self-checking bench for wishbone_arbiter2: a cycle-level behavioural model
// of the arbiter (owner, round-robin memory, in-flight count, silent-cycle
// count) is compared against every output on every cycle, and directed
// scenarios pin the model with hand-computed literal expectations.
module tb_wishbone_arbiter2;

  localparam int AW      = 2;
  localparam int DW      = 32;
  localparam int OUTW    = 4;
  localparam int TIMEOUT = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_m0_cyc, i_m0_stb, i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_data;
  logic          o_m0_ack, o_m0_stall, o_m0_err;
  logic [DW-1:0] o_m0_data;
  logic          i_m1_cyc, i_m1_stb, i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_data;
  logic          o_m1_ack, o_m1_stall, o_m1_err;
  logic [DW-1:0] o_m1_data;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_data;
  logic          i_s_ack, i_s_stall, i_s_err;
  logic [DW-1:0] i_s_data;
  logic [1:0]    o_grant;

  always #5 i_clk = ~i_clk;

  wishbone_arbiter2 #(
    .AW(AW), .DW(DW), .OUTW(OUTW), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data),
    .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data),
    .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_err(i_s_err), .i_s_data(i_s_data),
    .o_grant(o_grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]    grant;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [1:0]    ack, stall, err;
    logic [DW-1:0] d0, d1;
    logic          to;
  } exp_t;

  int m_owner = -1;   // -1 none, else master index
  int m_last  = 1;    // master that owned the bus last
  int m_out   = 0;    // requests in flight
  int m_quiet = 0;    // owned cycles with work in flight and no response
  bit m_valid = 1'b0;

  function automatic exp_t expect_now();
    exp_t e;
    logic c, s, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit sat, live;
    e.grant = 2'b00; e.s_cyc = 1'b0; e.s_stb = 1'b0; e.s_we = 1'b0;
    e.s_addr = '0; e.s_data = '0; e.ack = 2'b00; e.stall = 2'b11; e.err = 2'b00;
    e.d0 = '0; e.d1 = '0; e.to = 1'b0;
    if (m_owner >= 0) begin
      c = (m_owner == 1) ? i_m1_cyc  : i_m0_cyc;
      s = (m_owner == 1) ? i_m1_stb  : i_m0_stb;
      w = (m_owner == 1) ? i_m1_we   : i_m0_we;
      a = (m_owner == 1) ? i_m1_addr : i_m0_addr;
      d = (m_owner == 1) ? i_m1_data : i_m0_data;
      sat  = (m_out == (1 << OUTW) - 1);
      live = (m_out > 0);
      e.to = TO_EN && live && (m_quiet + 1 == TIMEOUT) && !(i_s_ack || i_s_err);
      e.grant  = (m_owner == 1) ? 2'b10 : 2'b01;
      e.s_cyc  = c && !e.to;
      e.s_stb  = s && !sat && !e.to;
      e.s_we   = w;
      e.s_addr = a;
      e.s_data = d;
      e.stall[m_owner] = i_s_stall || sat;
      e.ack[m_owner]   = i_s_ack && live;
      e.err[m_owner]   = (i_s_err && live) || e.to;
      if (m_owner == 0) e.d0 = i_s_data;
      else              e.d1 = i_s_data;
    end
    return e;
  endfunction

  // Advance the model on each rising edge from the inputs held across it.
  always @(posedge i_clk) begin
    exp_t e;
    logic c;
    e = expect_now();
    if (i_reset) begin
      m_owner = -1; m_last = 1; m_out = 0; m_quiet = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        if (i_m0_cyc && i_m1_cyc) m_owner = (m_last == 0) ? 1 : 0;
        else if (i_m0_cyc)        m_owner = 0;
        else if (i_m1_cyc)        m_owner = 1;
        m_quiet = 0;
      end else begin
        c = (m_owner == 1) ? i_m1_cyc : i_m0_cyc;
        if (!c || e.to) begin
          m_last = m_owner; m_owner = -1; m_out = 0; m_quiet = 0;
        end else begin
          if (i_s_ack || i_s_err) m_quiet = 0;
          else if (m_out > 0)     m_quiet++;
          if (e.s_stb && !i_s_stall)             m_out++;
          if ((i_s_ack || i_s_err) && m_out > 0 && !(e.s_stb && !i_s_stall && m_out == 1 && 0))
            ;
          if ((i_s_ack || i_s_err) && (m_out - ((e.s_stb && !i_s_stall) ? 1 : 0)) > 0) m_out--;
        end
      end
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge i_clk) begin
    exp_t e;
    if (m_valid) begin
      e = expect_now();
      check("cmp_grant",    o_grant,    e.grant);
      check("cmp_s_cyc",    o_s_cyc,    e.s_cyc);
      check("cmp_s_stb",    o_s_stb,    e.s_stb);
      check("cmp_s_we",     o_s_we,     e.s_we);
      check("cmp_s_addr",   o_s_addr,   e.s_addr);
      check("cmp_s_data",   o_s_data,   e.s_data);
      check("cmp_m0_ack",   o_m0_ack,   e.ack[0]);
      check("cmp_m1_ack",   o_m1_ack,   e.ack[1]);
      check("cmp_m0_stall", o_m0_stall, e.stall[0]);
      check("cmp_m1_stall", o_m1_stall, e.stall[1]);
      check("cmp_m0_err",   o_m0_err,   e.err[0]);
      check("cmp_m1_err",   o_m1_err,   e.err[1]);
      check("cmp_m0_data",  o_m0_data,  e.d0);
      check("cmp_m1_data",  o_m1_data,  e.d1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_data = '0;
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_data = '0;
    i_s_ack = 1'b0; i_s_stall = 1'b0; i_s_err = 1'b0; i_s_data = '0;
  endtask

  // Test 2 table: both masters raise CYC together three times.
  logic       t2_c0 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       t2_c1 [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] t2_g  [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

  // Test 3 table: three pipelined reads behind a 2-cycle slave stall.
  logic        t3_cyc   [11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
  logic        t3_stb   [11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  logic [1:0]  t3_addr  [11] = '{2'd0,2'd0,2'd0,2'd0,2'd1,2'd2,2'd0,2'd0,2'd0,2'd0,2'd0};
  logic        t3_sstl  [11] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  logic        t3_sack  [11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0};
  logic [31:0] t3_sdat  [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003,
                                 32'hDEAD_BEEF, 32'h0};
  logic        t3_estl  [11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  logic        t3_eack  [11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0};

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    check("rst_grant",    o_grant,    2'b00);
    check("rst_s_cyc",    o_s_cyc,    1'b0);
    check("rst_s_stb",    o_s_stb,    1'b0);
    check("rst_m0_stall", o_m0_stall, 1'b1);
    check("rst_m1_stall", o_m1_stall, 1'b1);
    check("rst_m0_ack",   o_m0_ack,   1'b0);
    check("rst_m0_err",   o_m0_err,   1'b0);

    // Test 1: single write from m0.
    next_cycle();
    i_reset = 1'b0;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b1; i_m0_addr = 2'd1; i_m0_data = 32'd1;
    sample();
    check("t1_grant_latency", o_grant, 2'b00);
    next_cycle();
    sample();
    check("t1_grant",    o_grant,    2'b01);
    check("t1_s_addr",   o_s_addr,   2'd1);
    check("t1_s_data",   o_s_data,   32'd1);
    check("t1_s_we",     o_s_we,     1'b1);
    check("t1_m0_stall", o_m0_stall, 1'b0);
    next_cycle();
    i_m0_stb = 1'b0; i_s_ack = 1'b1; i_s_data = 32'hCAFE_0001;
    sample();
    check("t1_m0_ack",   o_m0_ack,   1'b1);
    check("t1_m0_data",  o_m0_data,  32'hCAFE_0001);
    check("t1_m1_ack",   o_m1_ack,   1'b0);
    check("t1_m1_stall", o_m1_stall, 1'b1);
    check("t1_m1_data",  o_m1_data,  32'h0);
    next_cycle();
    idle_inputs();
    sample();
    check("t1_release_cyc", o_s_cyc, 1'b0);
    next_cycle();

    // Test 2: simultaneous requests alternate with one IDLE cycle between.
    i_reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      i_reset = 1'b0;
      i_m0_cyc = t2_c0[i];
      i_m1_cyc = t2_c1[i];
      sample();
      check($sformatf("t2_grant_%0d", i), o_grant, t2_g[i]);
    end

    // Test 3: pipelined reads with slave stall, then a stray ack.
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      i_m0_cyc = t3_cyc[i]; i_m0_stb = t3_stb[i]; i_m0_addr = t3_addr[i];
      i_s_stall = t3_sstl[i]; i_s_ack = t3_sack[i]; i_s_data = t3_sdat[i];
      sample();
      check($sformatf("t3_m0_stall_%0d", i), o_m0_stall, t3_estl[i]);
      check($sformatf("t3_m0_ack_%0d", i),   o_m0_ack,   t3_eack[i]);
      check($sformatf("t3_m0_data_%0d", i),  o_m0_data,  (i == 0) ? 32'h0 : t3_sdat[i]);
    end
    next_cycle();
    idle_inputs();

    // Test 4: slave error on m1's write; m0 waits until m1 drops CYC.
    next_cycle();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b1; i_m1_addr = 2'd3; i_m1_data = 32'h1234_5678;
    sample();
    check("t4_grant_idle", o_grant, 2'b00);
    next_cycle();
    sample();
    check("t4_grant",  o_grant,  2'b10);
    check("t4_s_addr", o_s_addr, 2'd3);
    check("t4_s_data", o_s_data, 32'h1234_5678);
    next_cycle();
    i_m1_stb = 1'b0; i_s_err = 1'b1;
    sample();
    check("t4_m1_err", o_m1_err, 1'b1);
    check("t4_m0_err", o_m0_err, 1'b0);
    check("t4_m1_ack", o_m1_ack, 1'b0);
    next_cycle();
    i_s_err = 1'b0; i_m0_cyc = 1'b1;
    sample();
    check("t4_m1_err_gone", o_m1_err,   1'b0);
    check("t4_grant_held",  o_grant,    2'b10);
    check("t4_m0_stall",    o_m0_stall, 1'b1);
    next_cycle();
    i_m1_cyc = 1'b0;
    sample();
    check("t4_grant_last", o_grant, 2'b10);
    next_cycle();
    sample();
    check("t4_gap", o_grant, 2'b00);
    next_cycle();
    i_m0_cyc = 1'b0;
    sample();
    check("t4_handoff", o_grant, 2'b01);
    next_cycle();

    // Test 5: reset while m1 has two requests in flight.
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b0; i_m1_addr = 2'd0;
    next_cycle();
    sample();
    check("t5_grant", o_grant, 2'b10);
    next_cycle();
    i_m1_addr = 2'd1;
    next_cycle();
    i_m1_stb = 1'b0; i_reset = 1'b1;
    sample();
    check("t5_grant_before_rst", o_grant, 2'b10);
    next_cycle();
    i_reset = 1'b0; i_m1_cyc = 1'b0; i_s_ack = 1'b1; i_s_data = 32'h0BAD_0BAD;
    sample();
    check("t5_grant_rst", o_grant,   2'b00);
    check("t5_s_cyc_rst", o_s_cyc,   1'b0);
    check("t5_late_ack",  o_m1_ack,  1'b0);
    check("t5_late_data", o_m1_data, 32'h0);
    next_cycle();
    idle_inputs();

    // Test 6: slave never answers m0's strobe; m1 queues behind.
    next_cycle();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 2'd2;
    next_cycle();
    sample();
    check("t6_grant", o_grant, 2'b01);
    for (int i = 2; i <= 8; i++) begin
      next_cycle();
      i_m0_stb = 1'b0; i_m1_cyc = 1'b1;
      sample();
      check($sformatf("t6_quiet_err_%0d", i), o_m0_err, 1'b0);
    end
    next_cycle();
    sample();
    check("t6_err_pulse", o_m0_err, TO_EN ? 1'b1 : 1'b0);
    check("t6_s_cyc",     o_s_cyc,  TO_EN ? 1'b0 : 1'b1);
    next_cycle();
    i_m0_cyc = 1'b0;
    sample();
    check("t6_err_once",  o_m0_err, 1'b0);
    check("t6_grant_10",  o_grant,  TO_EN ? 2'b00 : 2'b01);
    next_cycle();
    sample();
    check("t6_grant_11",  o_grant,  TO_EN ? 2'b10 : 2'b00);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

`ifndef WB_TIMEOUT_EN
    // Test 7: outstanding counter saturation throttles the owner.
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      if (i > 0) next_cycle();
      i_s_ack = (i == 17);
      sample();
      if (i == 16) begin
        check("t7_sat_stall", o_m0_stall, 1'b1);
        check("t7_sat_stb",   o_s_stb,    1'b0);
      end
      if (i == 18) begin
        check("t7_unsat_stall", o_m0_stall, 1'b0);
        check("t7_unsat_stb",   o_s_stb,    1'b1);
      end
    end
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
